// File: rtl/des_decrypt_core_if.sv
// Request/response bundle shared by the DES cores: start request, key and block in,
// plaintext and status out.
interface des_decrypt_core_if;
   logic        load;
   logic [63:0] key_in;
   logic [63:0] data_in;
   logic [63:0] data_out;
   logic        busy;
   logic        done;
   logic        key_err;

   modport master (output load, key_in, data_in, input data_out, busy, done, key_err);
   modport slave  (input load, key_in, data_in, output data_out, busy, done, key_err);
endinterface

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, subkeys derived on the fly
// from K16 down to K1 by rotating C/D right.
module des_decrypt_core #(
   parameter bit PAR_CHECK = 1'b0
) (
   input logic               clk,
   input logic               reset,
   des_decrypt_core_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, ROUND = 1'b1} state_t;

   localparam logic [7:0] IP_T [64] = '{
      8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,  8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
      8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,  8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
      8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
      8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,  8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7};
   localparam logic [7:0] FP_T [64] = '{
      8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32, 8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
      8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30, 8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
      8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28, 8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
      8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26, 8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25};
   localparam logic [7:0] E_T [48] = '{
      8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,  8'd8,  8'd9,  8'd10, 8'd11,
      8'd12, 8'd13, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd20, 8'd21,
      8'd22, 8'd23, 8'd24, 8'd25, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1};
   localparam logic [7:0] P_T [32] = '{
      8'd16, 8'd7, 8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17, 8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
      8'd2,  8'd8, 8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,  8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25};
   localparam logic [7:0] PC1_T [56] = '{
      8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
      8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36, 8'd63, 8'd55, 8'd47, 8'd39,
      8'd31, 8'd23, 8'd15, 8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37,
      8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4};
   localparam logic [7:0] PC2_T [48] = '{
      8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10, 8'd23, 8'd19, 8'd12, 8'd4,
      8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,  8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40,
      8'd51, 8'd45, 8'd33, 8'd48, 8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32};
   // One entry per S-box row (box*4 + row); column 0 is the most significant nibble.
   localparam logic [63:0] SBOX_T [32] = '{
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
      64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

   function automatic logic key_parity_ok(input logic [63:0] key);
      key_parity_ok = 1'b1;
      for (int i = 0; i < 8; i++) key_parity_ok &= ^key[8*i +: 8];
   endfunction

   function automatic logic [63:0] ip_perm(input logic [63:0] x);
      for (int k = 0; k < 64; k++) ip_perm[63-k] = x[64 - int'(IP_T[k])];
   endfunction

   function automatic logic [63:0] fp_perm(input logic [63:0] x);
      for (int k = 0; k < 64; k++) fp_perm[63-k] = x[64 - int'(FP_T[k])];
   endfunction

   function automatic logic [55:0] pc1_perm(input logic [63:0] x);
      for (int k = 0; k < 56; k++) pc1_perm[55-k] = x[64 - int'(PC1_T[k])];
   endfunction

   function automatic logic [47:0] pc2_perm(input logic [55:0] x);
      for (int k = 0; k < 48; k++) pc2_perm[47-k] = x[56 - int'(PC2_T[k])];
   endfunction

   function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [5:0]  b;
      logic [31:0] s;
      int          row;
      int          col;
      for (int n = 0; n < 48; n++) x[47-n] = r[32 - int'(E_T[n])];
      x = x ^ k;
      s = 32'h0;
      for (int j = 0; j < 8; j++) begin
         b   = x[47-6*j -: 6];
         row = int'({b[5], b[0]});
         col = int'(b[4:1]);
         s[31-4*j -: 4] = SBOX_T[j*4 + row][63-4*col -: 4];
      end
      for (int n = 0; n < 32; n++) f_func[31-n] = s[32 - int'(P_T[n])];
   endfunction

   state_t      state_r, state_s;
   logic [4:0]  cnt_r;
   logic [31:0] l_r, r_r, r_new_s;
   logic [27:0] c_r, d_r, c_rot_s, d_rot_s;
   logic [47:0] subkey_s;
   logic [63:0] data_out_r;
   logic        busy_r, done_r, key_err_r;
   logic        key_ok_s, start_s, reject_s;

   assign key_ok_s = !PAR_CHECK || key_parity_ok(bus.key_in);
   assign start_s  = (state_r == IDLE) && bus.load && key_ok_s;
   assign reject_s = (state_r == IDLE) && bus.load && !key_ok_s;

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (start_s) state_s = ROUND; else state_s = IDLE;
         ROUND:   if (cnt_r == 5'd16) state_s = IDLE; else state_s = ROUND;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state_r <= IDLE;
      else        state_r <= state_s;
   end

   // Reverse key schedule and one Feistel round; round 1 needs no rotation since C16 == C0.
   always_comb begin
      c_rot_s = c_r;
      d_rot_s = d_r;
      case (cnt_r)
         5'd1:              begin c_rot_s = c_r; d_rot_s = d_r; end
         5'd2, 5'd9, 5'd16: begin c_rot_s = {c_r[0], c_r[27:1]};   d_rot_s = {d_r[0], d_r[27:1]};   end
         default:           begin c_rot_s = {c_r[1:0], c_r[27:2]}; d_rot_s = {d_r[1:0], d_r[27:2]}; end
      endcase
      subkey_s = pc2_perm({c_rot_s, d_rot_s});
      r_new_s  = l_r ^ f_func(r_r, subkey_s);
   end

   // Datapath and registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_r      <= 5'd0;
         l_r        <= 32'h0;
         r_r        <= 32'h0;
         c_r        <= 28'h0;
         d_r        <= 28'h0;
         data_out_r <= 64'h0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         key_err_r  <= 1'b0;
      end else begin
         done_r    <= 1'b0;
         key_err_r <= reject_s;
         if (start_s) begin
            {l_r, r_r} <= ip_perm(bus.data_in);
            {c_r, d_r} <= pc1_perm(bus.key_in);
            cnt_r      <= 5'd1;
            busy_r     <= 1'b1;
         end else if (state_r == ROUND) begin
            c_r <= c_rot_s;
            d_r <= d_rot_s;
            l_r <= r_r;
            r_r <= r_new_s;
            if (cnt_r == 5'd16) begin
               data_out_r <= fp_perm({r_new_s, r_r});
               done_r     <= 1'b1;
               busy_r     <= 1'b0;
               cnt_r      <= 5'd0;
            end else begin
               cnt_r <= cnt_r + 5'd1;
            end
         end else begin
            busy_r <= 1'b0;
         end
      end
   end

   assign bus.data_out = data_out_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.key_err  = key_err_r;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: known-answer DES vectors plus handshake corner cases,
// with a second instance built with the key parity check enabled.
module tb_des_decrypt_core;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   des_decrypt_core_if bus_a();
   des_decrypt_core_if bus_p();

   des_decrypt_core #(.PAR_CHECK(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   des_decrypt_core #(.PAR_CHECK(1'b1)) dut_p (.clk(clk), .reset(reset), .bus(bus_p));

   typedef struct {
      logic [63:0] key;
      logic [63:0] ct;
      logic [63:0] pt;
   } vec_t;

   vec_t vecs [14];
   int checks     = 0;
   int failures   = 0;
   int done_cnt_a = 0;

   always @(posedge clk) if (bus_a.done === 1'b1) done_cnt_a <= done_cnt_a + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic pulse_load(input logic [63:0] k, input logic [63:0] d);
      bus_a.load    = 1'b1;
      bus_a.key_in  = k;
      bus_a.data_in = d;
      @(negedge clk);
      bus_a.load    = 1'b0;
      bus_a.key_in  = {$urandom, $urandom};
      bus_a.data_in = {$urandom, $urandom};
   endtask

   task automatic await_result(input string nm, input logic [63:0] exp, input int lat0);
      int lat;
      int busy_n;
      lat    = lat0;
      busy_n = lat0;
      while (bus_a.done !== 1'b1 && lat < 40) begin
         if (bus_a.busy === 1'b1) busy_n++;
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, 64'(lat), 64'd16);
      chk({nm, " busy cycles"}, 64'(busy_n), 64'd16);
      chk({nm, " busy at done"}, 64'(bus_a.busy), 64'd0);
      chk({nm, " data_out"}, bus_a.data_out, exp);
   endtask

   initial begin
      int d0;
      int lat;
      vecs[0]  = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
      vecs[1]  = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787};
      vecs[2]  = '{64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};
      vecs[3]  = '{64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF};
      vecs[4]  = '{64'h3000000000000000, 64'h958E6E627A05557B, 64'h1000000000000001};
      vecs[5]  = '{64'h1111111111111111, 64'hF40379AB9E0EC533, 64'h1111111111111111};
      vecs[6]  = '{64'h0123456789ABCDEF, 64'h17668DFC7292532D, 64'h1111111111111111};
      vecs[7]  = '{64'h1111111111111111, 64'h8A5AE1F81AB8F2DD, 64'h0123456789ABCDEF};
      vecs[8]  = '{64'hFEDCBA9876543210, 64'hED39D950FA74BCC4, 64'h0123456789ABCDEF};
      vecs[9]  = '{64'h7CA110454A1A6E57, 64'h690F5B0D9A26939B, 64'h01A1D6D039776742};
      vecs[10] = '{64'h0131D9619DC1376E, 64'h7A389D10354BD271, 64'h5CD54CA83DEF57DA};
      // DES complementation property: complementing key and plaintext complements the ciphertext.
      vecs[11] = '{~vecs[0].key, ~vecs[0].ct, ~vecs[0].pt};
      vecs[12] = '{~vecs[4].key, ~vecs[4].ct, ~vecs[4].pt};
      vecs[13] = '{~vecs[9].key, ~vecs[9].ct, ~vecs[9].pt};

      bus_a.load = 1'b0; bus_a.key_in = 64'h0; bus_a.data_in = 64'h0;
      bus_p.load = 1'b0; bus_p.key_in = 64'h0; bus_p.data_in = 64'h0;
      repeat (3) @(negedge clk);
      chk("reset data_out", bus_a.data_out, 64'h0);
      chk("reset busy", 64'(bus_a.busy), 64'd0);
      chk("reset done", 64'(bus_a.done), 64'd0);
      chk("reset key_err", 64'(bus_p.key_err), 64'd0);
      reset = 1'b1;

      @(negedge clk);
      pulse_load(vecs[0].key, vecs[0].ct);
      await_result("fips", vecs[0].pt, 0);

      pulse_load(vecs[1].key, vecs[1].ct);
      chk("b2b done falls", 64'(bus_a.done), 64'd0);
      chk("b2b busy rises", 64'(bus_a.busy), 64'd1);
      await_result("b2b", vecs[1].pt, 0);

      @(negedge clk);
      d0 = done_cnt_a;
      pulse_load(vecs[0].key, vecs[0].ct);
      repeat (4) @(negedge clk);
      bus_a.load    = 1'b1;
      bus_a.key_in  = {$urandom, $urandom};
      bus_a.data_in = {$urandom, $urandom};
      @(negedge clk);
      bus_a.load = 1'b0;
      await_result("load while busy", vecs[0].pt, 5);
      repeat (2) @(negedge clk);
      chk("load while busy done count", 64'(done_cnt_a - d0), 64'd1);

      pulse_load(vecs[0].key, vecs[0].ct);
      repeat (7) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("abort data_out", bus_a.data_out, 64'h0);
      chk("abort busy", 64'(bus_a.busy), 64'd0);
      chk("abort done", 64'(bus_a.done), 64'd0);
      d0 = done_cnt_a;
      repeat (20) @(negedge clk);
      chk("abort no done", 64'(done_cnt_a - d0), 64'd0);
      pulse_load(vecs[8].key, vecs[8].ct);
      await_result("after abort", vecs[8].pt, 0);

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         pulse_load(vecs[i].key, vecs[i].ct);
         await_result($sformatf("vec%0d", i), vecs[i].pt, 0);
      end

      bus_p.load    = 1'b1;
      bus_p.key_in  = vecs[0].key;
      bus_p.data_in = vecs[0].ct;
      @(negedge clk);
      bus_p.load = 1'b0;
      lat = 0;
      while (bus_p.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("parity good key latency", 64'(lat), 64'd16);
      chk("parity good key data_out", bus_p.data_out, vecs[0].pt);

      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         bus_p.load    = 1'b1;
         bus_p.key_in  = (t == 0) ? 64'h0000000000000000 : 64'hFFFFFFFFFFFFFFFF;
         bus_p.data_in = {$urandom, $urandom};
         @(negedge clk);
         bus_p.load = 1'b0;
         chk($sformatf("bad key%0d key_err", t), 64'(bus_p.key_err), 64'd1);
         chk($sformatf("bad key%0d busy", t), 64'(bus_p.busy), 64'd0);
         chk($sformatf("bad key%0d data_out", t), bus_p.data_out, vecs[0].pt);
         @(negedge clk);
         chk($sformatf("bad key%0d key_err pulse", t), 64'(bus_p.key_err), 64'd0);
         repeat (20) @(negedge clk);
         chk($sformatf("bad key%0d no run", t), {bus_p.data_out[63:2], bus_p.busy, bus_p.done},
             {vecs[0].pt[63:2], 2'b00});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/des_decrypt_core.md
Name: des_decrypt_core

Overview:
Iterative DES decryption core (FIPS 46-3). It is the inverse of the team's DES encryption core: a ciphertext block and 64-bit key go in, and the plaintext comes out after 16 clock cycles, one Feistel round per cycle. The subkeys are generated on the fly in reverse order (K16 first). It sits on the receive side of the datapath and shares the same load/key_in/data_in/data_out interface style as the encryptor, so encrypt→decrypt loopback benches can chain the two directly.

Parameters:
PAR_CHECK, 0, when 1 a key with any byte of even parity is rejected at load (key_err pulses, no operation starts); when 0 the parity bits (key_in[56],[48],...,[0]) are ignored.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
load  input  1  start request; sampled each rising edge
key_in  input  64  DES key incl. parity bits, MSB = bit 1 in FIPS numbering
data_in  input  64  ciphertext block, same bit order
data_out  output  64  plaintext block, registered
busy  output  1  high while rounds are in progress
done  output  1  single-cycle pulse: data_out updated
key_err  output  1  single-cycle pulse: load rejected by parity check (only possible with PAR_CHECK=1)

Behaviour:
- Reset (reset==0 at an edge): state IDLE; data_out=64'h0, busy=0, done=0, key_err=0; round counter=0; L/R/C/D registers cleared. Reset mid-operation aborts the block silently: no done pulse, and data_out returns to 0.
- States: IDLE, ROUND. No separate output state.
- IDLE and load=1 at edge N (with key accepted): L,R <= IP(data_in); C,D <= PC1(key_in); round counter <= 1; busy <= 1; state <= ROUND.
- Key accepted = PAR_CHECK==0, or every key byte has odd parity. If rejected: key_err=1 for one cycle after edge N, state stays IDLE, and data_out is unchanged.
- ROUND, counter i=1..16 (edges N+1..N+16):
  - Rotate C,D right by 0 when i=1, by 1 when i∈{2,9,16}, otherwise by 2.
  - Subkey = PC2 of the rotated C,D. For i=1 this equals K16, because the encryption schedule's total left rotation is 28.
  - L <= R; R <= L ^ f(R, subkey). f = P(S-boxes(E(R)^subkey)) using the standard 8 S-boxes.
- Edge N+16 (i=16):
  - data_out <= FP({R_new, L_new}), i.e. with the final swap undone.
  - done=1 for exactly one cycle; busy=0; state <= IDLE.
- Latency: load accepted at edge N → data_out valid and done=1 after edge N+16. Throughput is one block per 16 cycles when reloading on the done cycle, and one per 17 cycles otherwise.
- load while busy=1: ignored, with no effect on the operation in flight. key_in/data_in are not required to stay stable after the accepting edge.
- load=1 in the cycle done=1: state is IDLE, so the load is accepted (back-to-back). done falls, busy rises.
- data_out holds its last plaintext until the next completion or reset.
- Key/data of X or Z are not checked. All logic runs in a single clock domain, and the async-style reset is not used.

Test Plan:
1. Reset then FIPS vector: key 133457799BBCDFF1, data_in 85E813540F0AB405, load for 1 cycle → done exactly 16 cycles after the accepting edge, data_out=0123456789ABCDEF, busy high for 16 cycles.
2. Second vector back-to-back: reassert load on the done cycle with key 0E329232EA6D0D73 and data_in 0000000000000000 → accepted immediately, data_out=8787878787878787 after 16 more cycles.
3. Load while busy: pulse load with random key/data at cycle 5 of case 1 → ignored; result is still 0123456789ABCDEF and the done count stays 1.
4. Reset mid-operation: drop reset at round 8 for one cycle → data_out=0, busy=0, and no done pulse. A fresh load then gives the correct result.
5. Parity (PAR_CHECK=1): key 0000000000000000 → key_err pulse, busy stays 0, data_out unchanged. Key 133457799BBCDFF1 is accepted. With PAR_CHECK=0 the all-zero key is accepted.
6. Loopback: 1000 random key/plaintext pairs through the DES encryption core into this block → recovered plaintext equals the original every time.
